// File: rtl/puf_tmv_stabilizer.sv
// puf_tmv_stabilizer
//   Temporal-majority-vote stabilizer for the DAPUF response array. Each key
//   is built from NSAMP evaluations of the same challenge: every evaluation
//   is requested with a one-cycle eval_req pulse, the returned word is
//   accumulated into per-bit ones counters, and at the end each key bit is
//   the majority value. Bits that were not unanimous are flagged in
//   unstable_mask.
//
//   Optional feature macro: TMV_TIMEOUT_EN
//     Defined   - a wait counter runs in WAIT. If TIMEOUT_CYC cycles pass
//                 without resp_valid, err is set (sticky) and the FSM returns
//                 to IDLE without pulsing key_valid. err clears on start.
//     Undefined - WAIT holds indefinitely and err is tied 0.
//
// Ports
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   start         in   begin key generation (sampled only in IDLE)
//   eval_req      out  one-cycle pulse requesting a PUF evaluation
//   resp_in       in   [WIDTH] PUF response word
//   resp_valid    in   resp_in valid this cycle (honoured only in WAIT)
//   busy          out  high in every state except IDLE
//   key_out       out  [WIDTH] majority-voted key, held until next DONE
//   unstable_mask out  [WIDTH] bit i set if bit i was not unanimous
//   key_valid     out  one-cycle pulse when key_out/unstable_mask update
//   err           out  sticky timeout flag (TMV_TIMEOUT_EN only)

module puf_tmv_stabilizer #(
   parameter int WIDTH       = 16,
   parameter int NSAMP       = 15,
   parameter int CNT_W       = 8,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             eval_req,
   input  logic [WIDTH-1:0] resp_in,
   input  logic             resp_valid,
   output logic             busy,
   output logic [WIDTH-1:0] key_out,
   output logic [WIDTH-1:0] unstable_mask,
   output logic             key_valid,
   output logic             err
);

   // Parameter sanity: an even NSAMP has no strict majority, and the
   // counters must be able to hold NSAMP without wrapping.
   if ((NSAMP % 2) == 0 || NSAMP < 3 || NSAMP > 255) begin : g_bad_nsamp
      $error("puf_tmv_stabilizer: NSAMP must be odd and within 3..255");
   end
   if ((2 ** CNT_W) <= NSAMP) begin : g_bad_cnt_w
      $error("puf_tmv_stabilizer: CNT_W too narrow for NSAMP");
   end
   if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("puf_tmv_stabilizer: TIMEOUT_CYC must be at least 1");
   end

   localparam logic [CNT_W-1:0] NSAMP_C = CNT_W'(NSAMP);
   localparam logic [CNT_W-1:0] HALF_C  = CNT_W'(NSAMP / 2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_ACCUM,
      S_DONE
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] ones_cnt [WIDTH];
   logic [CNT_W-1:0] sample_cnt;
   logic             start_ok;   // start accepted this cycle
   logic             resp_ok;    // response accepted this cycle
   logic             timeout;    // WAIT budget exhausted this cycle

   assign start_ok = (state == S_IDLE) && start;
   assign resp_ok  = (state == S_WAIT) && resp_valid;
   assign eval_req = (state == S_REQ);
   assign busy     = (state != S_IDLE);

`ifdef TMV_TIMEOUT_EN
   localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

   logic [WAIT_W-1:0] wait_cnt;

   // wait_cnt counts completed WAIT cycles of the current request, so the
   // TIMEOUT_CYC-th silent WAIT cycle is the one that gives up.
   assign timeout = (state == S_WAIT) && !resp_valid && (wait_cnt == WAIT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= '0;
         err      <= 1'b0;
      end else begin
         if (state == S_WAIT && !resp_valid) wait_cnt <= wait_cnt + 1'b1;
         else                                 wait_cnt <= '0;

         if (start_ok)     err <= 1'b0;
         else if (timeout) err <= 1'b1;
      end
   end
`else
   assign timeout = 1'b0;
   assign err     = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of the others.
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      // NOTE: default first, so no path through the case leaves state_nxt
      // unassigned and no latch is inferred.
      state_nxt = state;
      unique case (state)
         S_IDLE:  if (start) state_nxt = S_REQ;
         S_REQ:   state_nxt = S_WAIT;
         S_WAIT: begin
            if (resp_valid)   state_nxt = S_ACCUM;
            else if (timeout) state_nxt = S_IDLE;
         end
         S_ACCUM: state_nxt = (sample_cnt == NSAMP_C) ? S_DONE : S_REQ;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Accumulators. A start clears them; resp_valid outside WAIT is ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the counter array is small and has a defined reset value,
         // so it is reset like ordinary flops rather than treated as RAM.
         for (int i = 0; i < WIDTH; i++) ones_cnt[i] <= '0;
         sample_cnt <= '0;
      end else if (start_ok) begin
         for (int i = 0; i < WIDTH; i++) ones_cnt[i] <= '0;
         sample_cnt <= '0;
      end else if (resp_ok) begin
         for (int i = 0; i < WIDTH; i++) ones_cnt[i] <= ones_cnt[i] + CNT_W'(resp_in[i]);
         sample_cnt <= sample_cnt + 1'b1;
      end
   end

   // Vote. Registered at the end of DONE, so key_valid rises together with
   // the new key_out/unstable_mask.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_out       <= '0;
         unstable_mask <= '0;
         key_valid     <= 1'b0;
      end else begin
         key_valid <= (state == S_DONE);
         if (state == S_DONE) begin
            for (int i = 0; i < WIDTH; i++) begin
               key_out[i]       <= (ones_cnt[i] > HALF_C);
               unstable_mask[i] <= (ones_cnt[i] != '0) && (ones_cnt[i] != NSAMP_C);
            end
         end
      end
   end

endmodule

// File: tb/tb_puf_tmv_stabilizer.sv
// Directed testbench for puf_tmv_stabilizer (WIDTH=16, NSAMP=15).
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_puf_tmv_stabilizer;

   localparam int WIDTH = 16;
   localparam int NSAMP = 15;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic             eval_req;
   logic [WIDTH-1:0] resp_in = '0;
   logic             resp_valid = 1'b0;
   logic             busy;
   logic [WIDTH-1:0] key_out;
   logic [WIDTH-1:0] unstable_mask;
   logic             key_valid;
   logic             err;

   int checks = 0;
   int errors = 0;
   int req_cnt = 0;   // eval_req cycles since time 0
   int kv_cnt  = 0;   // key_valid cycles since time 0

   logic [WIDTH-1:0] samp [NSAMP];

   puf_tmv_stabilizer #(
      .WIDTH(WIDTH), .NSAMP(NSAMP), .CNT_W(8), .TIMEOUT_CYC(255)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .eval_req(eval_req),
      .resp_in(resp_in), .resp_valid(resp_valid), .busy(busy),
      .key_out(key_out), .unstable_mask(unstable_mask),
      .key_valid(key_valid), .err(err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (eval_req === 1'b1)  req_cnt++;
      if (key_valid === 1'b1) kv_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   // Start a key and answer the first n_resp evaluation requests from samp[].
   // If poke_start is set, start is re-asserted during the 5th sample.
   // If wait_key is set, waits for key_valid and returns start-to-key_valid
   // latency in cycles.
   task automatic run_key(input int n_resp, input bit poke_start, input bit wait_key,
                          output int cycles);
      int guard;
      start = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      cycles = 1;
      for (int k = 0; k < n_resp; k++) begin
         guard = 0;
         while (eval_req !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
            cycles++;
         end
         if (eval_req !== 1'b1) check("eval_req_seen", {31'b0, eval_req}, 32'd1);
         @(negedge clk);             // now in WAIT
         cycles++;
         if (poke_start && k == 4) start = 1'b1;
         resp_valid = 1'b1;
         resp_in    = samp[k];
         @(negedge clk);             // now in ACCUM
         cycles++;
         resp_valid = 1'b0;
         start      = 1'b0;
         resp_in    = '0;
      end
      if (wait_key) begin
         guard = 0;
         while (key_valid !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
            cycles++;
         end
         if (key_valid !== 1'b1) check("key_valid_seen", {31'b0, key_valid}, 32'd1);
      end
   endtask

   int lat;
   int req0;
   int kv0;
   int wait_cycles;

   initial begin
      // ---- reset state ----
      #12;
      check("rst_busy",      {31'b0, busy},      32'd0);
      check("rst_eval_req",  {31'b0, eval_req},  32'd0);
      check("rst_key_out",   {16'b0, key_out},   32'h0);
      check("rst_mask",      {16'b0, unstable_mask}, 32'h0);
      check("rst_key_valid", {31'b0, key_valid}, 32'd0);
      check("rst_err",       {31'b0, err},       32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // ---- spurious resp_valid in IDLE: no effect ----
      resp_valid = 1'b1;
      resp_in    = 16'hFFFF;
      repeat (3) @(negedge clk);
      resp_valid = 1'b0;
      resp_in    = '0;
      check("idle_resp_busy",    {31'b0, busy},    32'd0);
      check("idle_resp_key_out", {16'b0, key_out}, 32'h0);

      // ---- constant response A5A5 ----
      for (int k = 0; k < NSAMP; k++) samp[k] = 16'hA5A5;
      req0 = req_cnt;
      kv0  = kv_cnt;
      run_key(NSAMP, 1'b0, 1'b1, lat);
      check("const_key",     {16'b0, key_out},       32'hA5A5);
      check("const_mask",    {16'b0, unstable_mask}, 32'h0000);
      check("const_latency", lat,                    32'd47);
      @(negedge clk);
      check("const_reqs",    req_cnt - req0,         32'd15);
      check("const_kv_once", kv_cnt - kv0,           32'd1);
      check("const_kv_low",  {31'b0, key_valid},     32'd0);
      check("const_idle",    {31'b0, busy},          32'd0);

      // ---- start while busy ignored; prior key retained while busy ----
      for (int k = 0; k < NSAMP; k++) samp[k] = 16'h1234;
      req0 = req_cnt;
      kv0  = kv_cnt;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", {31'b0, busy},    32'd1);
      check("key_retained",     {16'b0, key_out}, 32'hA5A5);
      // finish this key with the helper's loop body (start already issued)
      rst_n = 1'b1;
      // abort and redo cleanly via helper so the poke path is exercised
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      run_key(NSAMP, 1'b1, 1'b1, lat);
      check("poke_key",     {16'b0, key_out},       32'h1234);
      check("poke_mask",    {16'b0, unstable_mask}, 32'h0000);
      check("poke_latency", lat,                    32'd47);
      @(negedge clk);
      check("poke_reqs",    req_cnt - req0,         32'd15);
      check("poke_kv_once", kv_cnt - kv0,           32'd1);

      // ---- reset during sample 9 after key 1234 ----
      for (int k = 0; k < NSAMP; k++) samp[k] = 16'hFFFF;
      run_key(8, 1'b0, 1'b0, lat);
      @(negedge clk);                // REQ of sample 9
      check("s9_req", {31'b0, eval_req}, 32'd1);
      @(negedge clk);                // WAIT of sample 9
      #2 rst_n = 1'b0;
      #1;
      check("midrst_busy", {31'b0, busy},          32'd0);
      check("midrst_key",  {16'b0, key_out},       32'h0);
      check("midrst_mask", {16'b0, unstable_mask}, 32'h0);
      check("midrst_req",  {31'b0, eval_req},      32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // ---- bit0 high in 8 of 15 samples over AAAA ----
      for (int k = 0; k < NSAMP; k++) samp[k] = (k < 8) ? 16'hAAAB : 16'hAAAA;
      run_key(NSAMP, 1'b0, 1'b1, lat);
      check("above_key",     {16'b0, key_out},       32'hAAAB);
      check("above_mask",    {16'b0, unstable_mask}, 32'h0001);
      check("above_latency", lat,                    32'd47);
      @(negedge clk);

      // ---- bit3 high in 7 of 15 samples, rest 0 ----
      for (int k = 0; k < NSAMP; k++) samp[k] = (k < 7) ? 16'h0008 : 16'h0000;
      run_key(NSAMP, 1'b0, 1'b1, lat);
      check("below_key",  {16'b0, key_out},       32'h0000);
      check("below_mask", {16'b0, unstable_mask}, 32'h0008);
      @(negedge clk);

      // ---- mixed: bit15 always 1, bit14 once, bit1 14 times ----
      for (int k = 0; k < NSAMP; k++)
         samp[k] = 16'h8000 | ((k == 0) ? 16'h4000 : 16'h0000) | ((k != 3) ? 16'h0002 : 16'h0000);
      run_key(NSAMP, 1'b0, 1'b1, lat);
      check("mixed_key",  {16'b0, key_out},       32'h8002);
      check("mixed_mask", {16'b0, unstable_mask}, 32'h4002);
      @(negedge clk);

`ifdef TMV_TIMEOUT_EN
      // ---- timeout after sample 3 ----
      kv0 = kv_cnt;
      run_key(3, 1'b0, 1'b0, lat);
      @(negedge clk);                // REQ of sample 4
      check("to_req", {31'b0, eval_req}, 32'd1);
      @(negedge clk);                // first WAIT cycle
      wait_cycles = 0;
      while (busy === 1'b1 && wait_cycles < 400) begin
         wait_cycles++;
         @(negedge clk);
      end
      check("to_wait_cycles", wait_cycles,             32'd255);
      check("to_err",         {31'b0, err},            32'd1);
      check("to_idle",        {31'b0, busy},           32'd0);
      check("to_no_kv",       kv_cnt - kv0,            32'd0);
      check("to_key_kept",    {16'b0, key_out},        32'h8002);
      check("to_mask_kept",   {16'b0, unstable_mask},  32'h4002);
      @(negedge clk);
      check("to_err_sticky",  {31'b0, err},            32'd1);
      for (int k = 0; k < NSAMP; k++) samp[k] = 16'h0F0F;
      run_key(NSAMP, 1'b0, 1'b1, lat);
      check("to_err_cleared", {31'b0, err},            32'd0);
      check("to_new_key",     {16'b0, key_out},        32'h0F0F);
      @(negedge clk);
`else
      // ---- without the timeout feature err stays low ----
      check("err_tied_low", {31'b0, err}, 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
